// File: rtl/store_commit_buffer.sv
// store_commit_buffer: post-commit store FIFO that drains one byte per granted memory cycle.
// Optional macro STORE_BUF_HAZARD_EN selects the exact per-entry load-overlap check.
module store_commit_buffer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob2sb_valid,
    input  logic [1:0]  rob_store_type,
    input  logic [31:0] rob_addr,
    input  logic [31:0] rob_value,
    output logic        sb_full_out,
    input  logic        flush_in,
    output logic        sb_req_out,
    input  logic        sb_grant_in,
    output logic [31:0] mem_a_out,
    output logic [7:0]  mem_dout_out,
    output logic        mem_wr_out,
    input  logic        io_buffer_full,
    input  logic [31:0] ld_addr,
    input  logic [2:0]  ld_size,
    output logic        ld_conflict_out,
    output logic        sb_empty_out
);

    typedef enum logic [1:0] {IDLE, REQ, WRITE} state_t;

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    state_t state, state_next;

    logic [1:0]       type_q  [DEPTH];
    logic [31:0]      addr_q  [DEPTH];
    logic [31:0]      value_q [DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic [PTR_W:0]   count;
    logic [1:0]       k, k_next;

    logic [31:0] head_addr, head_value;
    logic [2:0]  head_len;
    logic        io_blocked, fire, last, push, pop;

    function automatic logic [2:0] len_of(input logic [1:0] t);
        case (t)
            2'b00:   len_of = 3'd1;
            2'b01:   len_of = 3'd2;
            default: len_of = 3'd4;
        endcase
    endfunction

    assign head_addr  = addr_q[head];
    assign head_value = value_q[head];
    assign head_len   = len_of(type_q[head]);

    assign io_blocked = (head_addr[17:16] == 2'b11) && io_buffer_full;
    assign fire       = rdy_in && (state == WRITE) && sb_grant_in && !io_blocked;
    assign last       = ({1'b0, k} == (head_len - 3'd1));
    assign push       = rdy_in && rob2sb_valid && !sb_full_out;
    assign pop        = fire && last;

    assign sb_full_out  = (count == FULL_COUNT);
    assign sb_empty_out = (count == '0) && (state == IDLE);

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            state <= IDLE;
            k     <= '0;
        end else if (rdy_in) begin
            state <= state_next;
            k     <= k_next;
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            type_q[tail]  <= rob_store_type;
            addr_q[tail]  <= rob_addr;
            value_q[tail] <= rob_value;
        end
    end

    always_comb begin
        state_next   = state;
        k_next       = k;
        sb_req_out   = 1'b0;
        mem_wr_out   = 1'b0;
        mem_a_out    = '0;
        mem_dout_out = '0;
        case (state)
            IDLE: begin
                if (count != '0) state_next = REQ;
            end
            REQ: begin
                sb_req_out = 1'b1;
                if (sb_grant_in) begin
                    state_next = WRITE;
                    k_next     = '0;
                end
            end
            WRITE: begin
                sb_req_out   = 1'b1;
                mem_a_out    = head_addr + {30'b0, k};
                mem_dout_out = 8'(head_value >> {k, 3'b000});
                mem_wr_out   = fire;
                if (fire) begin
                    if (last) begin
                        state_next = IDLE;
                        k_next     = '0;
                    end else begin
                        k_next = k + 2'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef STORE_BUF_HAZARD_EN
    logic [PTR_W-1:0] off;
    logic [31:0]      e_addr, ld_end;
    logic             unused_inputs;

    // Entry i is live when its distance from head is below count, so the entry
    // currently being written stays visible until it pops.
    always_comb begin
        ld_conflict_out = 1'b0;
        off             = '0;
        e_addr          = '0;
        ld_end          = ld_addr + {29'b0, ld_size};
        for (int unsigned i = 0; i < DEPTH; i++) begin
            off    = PTR_W'(i) - head;
            e_addr = addr_q[i];
            if (({1'b0, off} < count) && (e_addr < ld_end) &&
                (ld_addr < e_addr + {29'b0, len_of(type_q[i])}))
                ld_conflict_out = 1'b1;
        end
    end

    assign unused_inputs = flush_in;
`else
    logic unused_inputs;

    assign ld_conflict_out = !sb_empty_out;
    assign unused_inputs   = ^{flush_in, ld_addr, ld_size};
`endif

    // Pushing while full drops the entry; flag it in simulation.
    always_ff @(posedge clk_in) begin
        if (rst_in && rdy_in && rob2sb_valid) assert (!sb_full_out);
    end

endmodule

// File: tb/tb_store_commit_buffer.sv
// Bench for store_commit_buffer: queue-level scoreboard checked every cycle plus directed timing literals.
module tb_store_commit_buffer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        rob2sb_valid = 1'b0;
    logic [1:0]  rob_store_type = '0;
    logic [31:0] rob_addr = '0;
    logic [31:0] rob_value = '0;
    logic        sb_full_out;
    logic        flush_in = 1'b0;
    logic        sb_req_out;
    logic        sb_grant_in = 1'b0;
    logic [31:0] mem_a_out;
    logic [7:0]  mem_dout_out;
    logic        mem_wr_out;
    logic        io_buffer_full = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [2:0]  ld_size = 3'd1;
    logic        ld_conflict_out;
    logic        sb_empty_out;

    store_commit_buffer #(.DEPTH(8), .PTR_W(3)) dut (
        .clk_in          (clk),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .rob2sb_valid    (rob2sb_valid),
        .rob_store_type  (rob_store_type),
        .rob_addr        (rob_addr),
        .rob_value       (rob_value),
        .sb_full_out     (sb_full_out),
        .flush_in        (flush_in),
        .sb_req_out      (sb_req_out),
        .sb_grant_in     (sb_grant_in),
        .mem_a_out       (mem_a_out),
        .mem_dout_out    (mem_dout_out),
        .mem_wr_out      (mem_wr_out),
        .io_buffer_full  (io_buffer_full),
        .ld_addr         (ld_addr),
        .ld_size         (ld_size),
        .ld_conflict_out (ld_conflict_out),
        .sb_empty_out    (sb_empty_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] value;
        int          len;
    } entry_t;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    entry_t mq[$];
    wr_t    wlog[$];
    int     done = 0;
    bit     mon_en = 0;

    function automatic int len_of(input logic [1:0] t);
        return (t == 2'b00) ? 1 : (t == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic model_conflict(input logic [31:0] la, input logic [2:0] ls);
        logic        r;
        logic [31:0] a;
        r = 1'b0;
`ifdef STORE_BUF_HAZARD_EN
        foreach (mq[i]) begin
            a = mq[i].addr;
            if (a < la + {29'b0, ls} && la < a + 32'(mq[i].len)) r = 1'b1;
        end
`else
        a = la;
        r = (mq.size() != 0);
`endif
        return r;
    endfunction

    // Compare outputs against the queue model, then advance the model to the next edge.
    always @(negedge clk) begin
        if (mon_en) begin
            bit accept;
            chk("empty", sb_empty_out, mq.size() == 0);
            chk("full", sb_full_out, mq.size() == DEPTH);
            chk("conflict", ld_conflict_out, model_conflict(ld_addr, ld_size));
            if (!sb_grant_in) chk("wr_no_grant", mem_wr_out, 0);
            if (mq.size() > 0 && io_buffer_full && mq[0].addr[17:16] == 2'b11)
                chk("wr_io_blocked", mem_wr_out, 0);
            if (mem_wr_out) begin
                wlog.push_back('{cyc, mem_a_out, mem_dout_out});
                chk("wr_pending", mq.size() != 0, 1);
                if (mq.size() != 0) begin
                    chk("wr_addr", mem_a_out, mq[0].addr + 32'(done));
                    chk("wr_data", mem_dout_out, (mq[0].value >> (8 * done)) & 32'hFF);
                end
            end
            if (!rst_in) begin
                mq.delete();
                done = 0;
            end else if (rdy_in) begin
                accept = rob2sb_valid && (mq.size() < DEPTH);
                if (mem_wr_out && mq.size() != 0) begin
                    if (done + 1 == mq[0].len) begin
                        void'(mq.pop_front());
                        done = 0;
                    end else begin
                        done++;
                    end
                end
                if (accept) mq.push_back('{rob_addr, rob_value, len_of(rob_store_type)});
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] t, input logic [31:0] a, input logic [31:0] v, output int c);
        rob2sb_valid   = 1'b1;
        rob_store_type = t;
        rob_addr       = a;
        rob_value      = v;
        c = cyc;
        tick();
        rob2sb_valid = 1'b0;
    endtask

    task automatic chk_wr(input string name, input int idx, input int c, input logic [31:0] a,
                          input logic [7:0] d);
        if (wlog.size() > idx) begin
            chk({name, "_cyc"}, wlog[idx].cyc, c);
            chk({name, "_addr"}, wlog[idx].addr, a);
            chk({name, "_data"}, {24'b0, wlog[idx].data}, {24'b0, d});
        end else begin
            chk({name, "_count"}, wlog.size(), idx + 1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int c;
        tick();
        mon_en = 1;
        tick(2);
        @(negedge clk);
        chk("rst_req", sb_req_out, 0);
        chk("rst_wr", mem_wr_out, 0);
        chk("rst_a", mem_a_out, 0);
        chk("rst_dout", mem_dout_out, 0);
        chk("rst_full", sb_full_out, 0);
        chk("rst_empty", sb_empty_out, 1);
        chk("rst_conflict", ld_conflict_out, 0);
        tick();
        rst_in = 1'b1;

        // single byte store, grant held
        sb_grant_in = 1'b1;
        wlog.delete();
        push(2'b00, 32'h0000_1003, 32'h0000_00AB, c);
        @(negedge clk);
        chk("sb_req_n1", sb_req_out, 0);
        tick();
        @(negedge clk);
        chk("sb_req_n2", sb_req_out, 1);
        tick(6);
        chk("sb_nwr", wlog.size(), 1);
        chk_wr("sb_b0", 0, c + 3, 32'h1003, 8'hAB);
        chk("sb_empty_after", sb_empty_out, 1);

        // word store, four consecutive bytes, low byte first
        wlog.delete();
        push(2'b10, 32'h0000_2000, 32'h1122_3344, c);
        tick(8);
        chk_wr("sw_b0", 0, c + 3, 32'h2000, 8'h44);
        chk_wr("sw_b1", 1, c + 4, 32'h2001, 8'h33);
        chk_wr("sw_b2", 2, c + 5, 32'h2002, 8'h22);
        chk_wr("sw_b3", 3, c + 6, 32'h2003, 8'h11);

        // fill with grant low, then drain in order
        sb_grant_in = 1'b0;
        for (int i = 0; i < 8; i++)
            push(2'(i % 3), 32'h5000 + 32'(16 * i), 32'hA0B0_C0D0 + 32'(i), c);
        @(negedge clk);
        chk("fill_full", sb_full_out, 1);
        chk("fill_not_empty", sb_empty_out, 0);
        tick();
        wlog.delete();
        sb_grant_in = 1'b1;
        tick(45);
        chk("drain_nwr", wlog.size(), 17);
        chk_wr("drain_first", 0, wlog.size() > 0 ? wlog[0].cyc : -1, 32'h5000, 8'hD0);
        chk_wr("drain_last", 16, wlog.size() > 16 ? wlog[16].cyc : -1, 32'h5071, 8'hC0);
        wlog.delete();
        push(2'b10, 32'h0000_6000, 32'hCAFE_F00D, c);
        tick(10);
        chk_wr("wrap_b0", 0, c + 3, 32'h6000, 8'h0D);
        chk_wr("wrap_b3", 3, c + 6, 32'h6003, 8'hCA);

        // grant dropped for three cycles after byte 1
        wlog.delete();
        push(2'b10, 32'h0000_3000, 32'hDDCC_BBAA, c);
        tick(4);
        sb_grant_in = 1'b0;
        tick(3);
        sb_grant_in = 1'b1;
        tick(5);
        chk_wr("gap_b0", 0, c + 3, 32'h3000, 8'hAA);
        chk_wr("gap_b1", 1, c + 4, 32'h3001, 8'hBB);
        chk_wr("gap_b2", 2, c + 8, 32'h3002, 8'hCC);
        chk_wr("gap_b3", 3, c + 9, 32'h3003, 8'hDD);

        // load hazard against a pending half store at 0x4002
        sb_grant_in = 1'b0;
        push(2'b01, 32'h0000_4002, 32'h0000_BEEF, c);
        ld_addr = 32'h4000;
        ld_size = 3'd4;
        @(negedge clk);
        chk("ld_4000", ld_conflict_out, 1);
        tick();
        ld_addr = 32'h4004;
        @(negedge clk);
`ifdef STORE_BUF_HAZARD_EN
        chk("ld_4004", ld_conflict_out, 0);
`else
        chk("ld_4004", ld_conflict_out, 1);
`endif
        tick();
        ld_addr = 32'h0;
        ld_size = 3'd1;
        sb_grant_in = 1'b1;
        tick(8);

        // IO sink full for five write cycles, flush pulse mid-store
        wlog.delete();
        io_buffer_full = 1'b1;
        push(2'b00, 32'h0003_0000, 32'h0000_005A, c);
        tick(3);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        @(negedge clk);
        chk("flush_keeps", sb_empty_out, 0);
        tick(3);
        io_buffer_full = 1'b0;
        tick(4);
        chk("io_nwr", wlog.size(), 1);
        chk_wr("io_b0", 0, c + 8, 32'h0003_0000, 8'h5A);

        // push lands in the same cycle as the previous pop
        wlog.delete();
        push(2'b10, 32'h0000_7000, 32'h0102_0304, c);
        tick(5);
        push(2'b00, 32'h0000_7100, 32'h0000_0077, c);
        tick(6);
        chk_wr("pp_b", 4, c + 3, 32'h7100, 8'h77);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
